// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM.
// Alternates masters on contention; one read in flight; 1-cycle latency.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   freeze              blocks new grants while high
//   mN_address/byteenable/read/write/writedata   requester N inputs
//   mN_waitrequest/readdata/readdatavalid        requester N outputs
//   mem_address/byteenable/chipselect/write/writedata/clken  RAM port
//   mem_readdata        RAM data, valid the cycle after the address edge
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5120
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];

  logic act0;
  logic act1;
  logic run;
  logic may0;
  logic may1;
  logic gnt0;
  logic gnt1;
  logic gnt;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_wr;
  logic              in_range;

  // last_grant: 0 = m0 served last, 1 = m1 served last
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wd_q;

  logic rd_valid;
  logic rd_owner;
  logic rd_oor;

  assign act0 = m0_read | m0_write;
  assign act1 = m1_read | m1_write;
  assign run  = reset_n & ~freeze;

  // may_N: master N would win this cycle if it asks.
  // Independent of its own request, so an idle master
  // sees waitrequest low exactly when it would be served.
  assign may0 = run & (~act1 | last_grant);
  assign may1 = run & (~act0 | ~last_grant);

  assign gnt0 = may0 & act0;
  assign gnt1 = may1 & act1;
  assign gnt  = gnt0 | gnt1;

  assign m0_waitrequest = ~may0;
  assign m1_waitrequest = ~may1;

  always_comb begin
    sel_addr = m0_address;
    sel_be   = m0_byteenable;
    sel_wd   = m0_writedata;
    sel_wr   = m0_write;
    unique case (1'b1)
      gnt1: begin
        sel_addr = m1_address;
        sel_be   = m1_byteenable;
        sel_wd   = m1_writedata;
        sel_wr   = m1_write;
      end
      default: ;
    endcase
  end

  assign in_range = {1'b0, sel_addr} < LIMIT;

  // Out-of-range accesses are accepted but never reach the RAM.
  assign mem_chipselect = gnt & in_range;
  assign mem_write      = mem_chipselect & sel_wr;
  assign mem_address    = gnt ? sel_addr : addr_q;
  assign mem_byteenable = gnt ? sel_be   : be_q;
  assign mem_writedata  = gnt ? sel_wd   : wd_q;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
    end else if (gnt) begin
      last_grant <= gnt1;
      addr_q     <= sel_addr;
      be_q       <= sel_be;
      wd_q       <= sel_wd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= gnt & ~sel_wr;
      if (gnt) begin
        rd_owner <= gnt1;
        rd_oor   <= ~in_range;
      end
    end
  end

  assign m0_readdatavalid = rd_valid & ~rd_owner;
  assign m1_readdatavalid = rd_valid & rd_owner;

  assign m0_readdata =
    (m0_readdatavalid & ~rd_oor) ? mem_readdata : '0;
  assign m1_readdata =
    (m1_readdatavalid & ~rd_oor) ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios then random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5120;

  logic        clk;
  logic        reset_n;
  logic        freeze;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM the arbiter drives: registered read, byte-enabled write
  bit [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      mem_readdata <= ram[mem_address];
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit [31:0] ref_mem [DEPTH];
  bit        lg;
  bit        pv, po;
  bit [31:0] pd;
  bit [12:0] h_a;
  bit [3:0]  h_be;
  bit [31:0] h_wd;

  // Observed outputs of the last checked cycle
  logic        o_w0, o_w1, o_rv0, o_rv1, o_cs, o_we;
  logic [31:0] o_rd0, o_rd1;

  // Who gets served: -1 none, 0 m0, 1 m1
  function automatic int arb(bit a0, bit a1, bit frz, bit l);
    if (frz) return -1;
    if (a0 && a1) return l ? 0 : 1;
    if (a0) return 0;
    if (a1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    lg = 1'b1; pv = 1'b0; po = 1'b0; pd = '0;
    h_a = '0; h_be = '0; h_wd = '0;
  endtask

  // Called at a negedge with inputs driven; checks, updates, next negedge.
  task automatic cyc();
    int g;
    bit a0, a1, wr, inr, ex0, ex1;
    bit [12:0] ga;
    bit [3:0]  gb;
    bit [31:0] gd;
    #1;
    a0 = m0_read || m0_write;
    a1 = m1_read || m1_write;
    g  = arb(a0, a1, freeze, lg);
    ga = (g == 1) ? m1_address : m0_address;
    gb = (g == 1) ? m1_byteenable : m0_byteenable;
    gd = (g == 1) ? m1_writedata : m0_writedata;
    wr = (g == 1) ? m1_write : m0_write;
    inr = ga < DEPTH;
    chk("wait0", m0_waitrequest, arb(1'b1, a1, freeze, lg) != 0);
    chk("wait1", m1_waitrequest, arb(a0, 1'b1, freeze, lg) != 1);
    chk("cs", mem_chipselect, g >= 0 && inr);
    chk("we", mem_write, g >= 0 && inr && wr);
    chk("addr", mem_address, (g >= 0) ? ga : h_a);
    chk("be", mem_byteenable, (g >= 0) ? gb : h_be);
    chk("wd", mem_writedata, (g >= 0) ? gd : h_wd);
    chk("clken", mem_clken, 1);
    ex0 = pv && !po;
    ex1 = pv && po;
    chk("rv0", m0_readdatavalid, ex0);
    chk("rv1", m1_readdatavalid, ex1);
    chk("rd0", m0_readdata, ex0 ? pd : 0);
    chk("rd1", m1_readdata, ex1 ? pd : 0);
    o_w0 = m0_waitrequest; o_w1 = m1_waitrequest;
    o_rv0 = m0_readdatavalid; o_rv1 = m1_readdatavalid;
    o_rd0 = m0_readdata; o_rd1 = m1_readdata;
    o_cs = mem_chipselect; o_we = mem_write;
    pv = 1'b0;
    if (g >= 0) begin
      lg = (g == 1);
      h_a = ga; h_be = gb; h_wd = gd;
      if (wr) begin
        if (inr)
          for (int b = 0; b < 4; b++)
            if (gb[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
      end else begin
        pv = 1'b1;
        po = (g == 1);
        pd = inr ? ref_mem[ga] : 32'h0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drv0(bit r, bit w, bit [12:0] a, bit [3:0] be,
                      bit [31:0] d);
    m0_read = r; m0_write = w; m0_address = a;
    m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drv1(bit r, bit w, bit [12:0] a, bit [3:0] be,
                      bit [31:0] d);
    m1_read = r; m1_write = w; m1_address = a;
    m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    drv0(0, 0, 13'h0, 4'h0, 32'h0);
    drv1(0, 0, 13'h0, 4'h0, 32'h0);
  endtask

  // Starts and ends on a negedge; requests are kept active during reset.
  task automatic do_reset();
    reset_n = 1'b0;
    drv0(1, 0, 13'h5, 4'hF, 32'h1);
    drv1(0, 1, 13'h6, 4'hF, 32'h2);
    #1;
    chk("rst wait0", m0_waitrequest, 1);
    chk("rst wait1", m1_waitrequest, 1);
    chk("rst rv0", m0_readdatavalid, 0);
    chk("rst rv1", m1_readdatavalid, 0);
    chk("rst rd0", m0_readdata, 0);
    chk("rst rd1", m1_readdata, 0);
    chk("rst cs", mem_chipselect, 0);
    chk("rst we", mem_write, 0);
    chk("rst addr", mem_address, 0);
    chk("rst be", mem_byteenable, 0);
    chk("rst wd", mem_writedata, 0);
    chk("rst clken", mem_clken, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
  endtask

  function automatic bit [12:0] rnd_addr();
    if ($urandom_range(0, 15) == 0)
      return 13'($urandom_range(DEPTH, 8191));
    return 13'($urandom_range(0, 31));
  endfunction

  task automatic rnd_master(bit sel);
    int k;
    bit [12:0] a;
    k = $urandom_range(0, 3);
    a = rnd_addr();
    if (sel)
      drv1(k == 1 || k == 3, k >= 2, a, 4'($urandom_range(0, 15)),
           $urandom);
    else
      drv0(k == 1 || k == 3, k >= 2, a, 4'($urandom_range(0, 15)),
           $urandom);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, g0;
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    freeze = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Alternating writes, then read both back
    drv0(0, 1, 13'h10, 4'hF, 32'h11223344);
    drv1(0, 1, 13'h20, 4'hF, 32'hAABBCCDD);
    cyc();
    chk("wr m0 first", o_w0, 0);
    chk("wr m1 waits", o_w1, 1);
    drv0(0, 0, 13'h0, 4'h0, 32'h0);
    cyc();
    chk("wr m1 second", o_w1, 0);
    drv0(1, 0, 13'h10, 4'hF, 32'h0);
    drv1(1, 0, 13'h20, 4'hF, 32'h0);
    cyc();
    chk("rd m0 first", o_w0, 0);
    drv0(0, 0, 13'h0, 4'h0, 32'h0);
    cyc();
    chk("rb m0 valid", o_rv0, 1);
    chk("rb m0 data", o_rd0, 32'h11223344);
    chk("rd m1 granted", o_w1, 0);
    idle();
    cyc();
    chk("rb m1 valid", o_rv1, 1);
    chk("rb m1 data", o_rd1, 32'hAABBCCDD);

    // Continuous reads from both masters for 8 cycles
    c0 = 0; c1 = 0; g0 = 0;
    for (int i = 0; i < 8; i++) begin
      drv0(1, 0, 13'($urandom_range(0, 31)), 4'hF, 32'h0);
      drv1(1, 0, 13'($urandom_range(0, 31)), 4'hF, 32'h0);
      cyc();
      chk("alt grant", o_w0, i % 2);
      c0 += int'(o_rv0); c1 += int'(o_rv1); g0 += int'(!o_w0);
    end
    idle();
    cyc();
    c0 += int'(o_rv0); c1 += int'(o_rv1);
    chk("burst rv0", c0, 4);
    chk("burst rv1", c1, 4);
    chk("burst g0", g0, 4);

    // Partial write over 0x11223344
    drv0(0, 1, 13'h10, 4'b0010, 32'h0000EE00);
    cyc();
    drv0(1, 0, 13'h10, 4'hF, 32'h0);
    cyc();
    idle();
    cyc();
    chk("partial", o_rd0, 32'h1122EE44);

    // Out-of-range write and read
    drv1(0, 1, 13'd5120, 4'hF, 32'hFFFFFFFF);
    cyc();
    chk("oor accept", o_w1, 0);
    chk("oor cs", o_cs, 0);
    chk("oor we", o_we, 0);
    drv1(1, 0, 13'd5120, 4'hF, 32'h0);
    cyc();
    drv1(0, 0, 13'h0, 4'h0, 32'h0);
    drv0(1, 0, 13'h0, 4'hF, 32'h0);
    cyc();
    chk("oor rv", o_rv1, 1);
    chk("oor rd", o_rd1, 0);
    idle();
    cyc();
    chk("loc0 kept", o_rd0, 0);

    // Freeze with a read already in flight
    drv0(1, 0, 13'h10, 4'hF, 32'h0);
    cyc();
    drv0(1, 0, 13'h20, 4'hF, 32'h0);
    freeze = 1'b1;
    cyc();
    chk("frz pend rv", o_rv0, 1);
    chk("frz pend rd", o_rd0, 32'h1122EE44);
    chk("frz wait a", o_w0, 1);
    cyc();
    chk("frz wait b", o_w0, 1);
    chk("frz wait m1", o_w1, 1);
    cyc();
    chk("frz wait c", o_w0, 1);
    freeze = 1'b0;
    cyc();
    chk("frz resume", o_w0, 0);
    idle();
    cyc();
    chk("frz rd", o_rd0, 32'hAABBCCDD);

    // Reset one cycle after a read is accepted
    drv0(1, 0, 13'h10, 4'hF, 32'h0);
    cyc();
    do_reset();
    drv0(1, 0, 13'h20, 4'hF, 32'h0);
    drv1(1, 0, 13'h10, 4'hF, 32'h0);
    cyc();
    chk("post rst rv", o_rv0, 0);
    chk("post rst tie m0", o_w0, 0);
    chk("post rst tie m1", o_w1, 1);
    idle();
    cyc();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rnd_master(1'b0);
      rnd_master(1'b1);
      freeze = ($urandom_range(0, 7) == 0);
      if (i == 250) do_reset();
      else cyc();
    end
    freeze = 1'b0;
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
